// File: rtl/pong_pkg.sv
// Shared constants, FSM encoding and saturation helper
// for the paddle position controller.
package pong_pkg;

   localparam int SCREEN_H    = 480;
   localparam int PADDLE_H    = 64;
   localparam int Y_W         = 10;
   localparam int SPEED_SHIFT = 1;
   localparam int DEAD_ZONE   = 2;
   localparam int MAX_STEP    = 8;

   localparam int YMAX_I = SCREEN_H - PADDLE_H;
   localparam int YCTR_I = YMAX_I / 2;

   localparam logic [Y_W-1:0] YMAX = Y_W'(YMAX_I);
   localparam logic [Y_W-1:0] YCTR = Y_W'(YCTR_I);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      CALC  = 2'b01,
      APPLY = 2'b10
   } state_t;

   // Clamp a signed intermediate Y into the legal range [0, YMAX].
   function automatic logic [Y_W-1:0] sat_y(
      input logic signed [Y_W+1:0] v
   );
      logic signed [Y_W+1:0] hi;
      hi = $signed({2'b00, YMAX});
      if (v < 0)
         return '0;
      else if (v > hi)
         return YMAX;
      else
         return v[Y_W-1:0];
   endfunction

endpackage

// File: rtl/paddle_slew.sv
// Paddle Y register: rate-limited slew toward the target
// once per frame, plus registered status flags.
module paddle_slew
   import pong_pkg::*;
(
   input  logic           clk_25MHz,
   input  logic           reset_n,
   input  logic           frame_tick,
   input  logic           enable,
   input  logic           center,
   input  logic [Y_W-1:0] target,
   input  logic [Y_W-1:0] target_nxt,
   output logic [Y_W-1:0] paddle_y,
   output logic           paddle_moving,
   output logic           at_top,
   output logic           at_bottom
);

   localparam logic signed [Y_W+1:0] STEP = (Y_W+2)'(MAX_STEP);
   localparam logic [Y_W-1:0] STEP_U = Y_W'(MAX_STEP);

   logic signed [Y_W+1:0] diff;
   logic [Y_W-1:0]        y_nxt;

   // Next paddle Y: recentre, or step toward the current target.
   always_comb begin
      diff  = $signed({2'b00, target}) - $signed({2'b00, paddle_y});
      y_nxt = paddle_y;
      if (center) begin
         y_nxt = YCTR;
      end else if (frame_tick && enable) begin
         if (diff > STEP)
            y_nxt = paddle_y + STEP_U;
         else if (diff < -STEP)
            y_nxt = paddle_y - STEP_U;
         else
            y_nxt = target;
      end
   end

   // Position register and flags computed from next-cycle values.
   always_ff @(posedge clk_25MHz or negedge reset_n) begin
      if (!reset_n) begin
         paddle_y      <= YCTR;
         paddle_moving <= 1'b0;
         at_top        <= 1'b0;
         at_bottom     <= 1'b0;
      end else begin
         paddle_y      <= y_nxt;
         paddle_moving <= (y_nxt != target_nxt);
         at_top        <= (y_nxt == '0);
         at_bottom     <= (y_nxt == YMAX);
      end
   end

endmodule

// File: rtl/paddle_position_ctrl.sv
// Integrates decoder mouse samples into a clamped target Y
// and slews the displayed paddle toward it each frame.
module paddle_position_ctrl
   import pong_pkg::*;
(
   input  logic           clk_25MHz,
   input  logic           reset_n,
   input  logic           paddle_dir,
   input  logic [7:0]     paddle_speed,
   input  logic           error_flag,
   input  logic           new_output_flag,
   input  logic           frame_tick,
   input  logic           enable,
   input  logic           center,
   output logic [Y_W-1:0] paddle_y,
   output logic           paddle_moving,
   output logic           at_top,
   output logic           at_bottom,
   output logic           sample_dropped
);

   state_t         state, state_nxt;
   logic           dir_q, dir_nxt;
   logic [7:0]     speed_q, speed_nxt;
   logic [7:0]     delta_q, delta_nxt;
   logic [7:0]     scaled;
   logic [Y_W-1:0] target, target_nxt;
   logic           dropped_nxt;

   logic signed [Y_W+1:0] t_ext, d_ext, sum;

   // Sample FSM: latch, scale with dead zone, then saturate into target.
   always_comb begin
      state_nxt   = state;
      dir_nxt     = dir_q;
      speed_nxt   = speed_q;
      delta_nxt   = delta_q;
      target_nxt  = target;
      dropped_nxt = 1'b0;
      scaled      = speed_q >> SPEED_SHIFT;
      t_ext       = $signed({2'b00, target});
      d_ext       = $signed({{(Y_W+2-8){1'b0}}, delta_q});
      sum         = dir_q ? (t_ext + d_ext) : (t_ext - d_ext);
      if (center) begin
         state_nxt  = IDLE;
         target_nxt = YCTR;
      end else begin
         case (state)
            IDLE: begin
               if (new_output_flag) begin
                  if (enable && !error_flag) begin
                     dir_nxt   = paddle_dir;
                     speed_nxt = paddle_speed;
                     state_nxt = CALC;
                  end else begin
                     dropped_nxt = 1'b1;
                  end
               end
            end
            CALC: begin
               dropped_nxt = new_output_flag;
               if (scaled < 8'(DEAD_ZONE))
                  delta_nxt = '0;
               else
                  delta_nxt = scaled;
               state_nxt = APPLY;
            end
            APPLY: begin
               dropped_nxt = new_output_flag;
               if (enable)
                  target_nxt = sat_y(sum);
               state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // FSM, latched sample and target registers.
   always_ff @(posedge clk_25MHz or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         dir_q          <= 1'b0;
         speed_q        <= '0;
         delta_q        <= '0;
         target         <= YCTR;
         sample_dropped <= 1'b0;
      end else begin
         state          <= state_nxt;
         dir_q          <= dir_nxt;
         speed_q        <= speed_nxt;
         delta_q        <= delta_nxt;
         target         <= target_nxt;
         sample_dropped <= dropped_nxt;
      end
   end

   paddle_slew u_slew (
      .clk_25MHz     (clk_25MHz),
      .reset_n       (reset_n),
      .frame_tick    (frame_tick),
      .enable        (enable),
      .center        (center),
      .target        (target),
      .target_nxt    (target_nxt),
      .paddle_y      (paddle_y),
      .paddle_moving (paddle_moving),
      .at_top        (at_top),
      .at_bottom     (at_bottom)
   );

endmodule

// File: tb/tb_paddle_position_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic
// against an arithmetic model of target and paddle position.
module tb_paddle_position_ctrl;
   import pong_pkg::*;

   logic       clk_25MHz = 1'b0;
   logic       reset_n;
   logic       paddle_dir;
   logic [7:0] paddle_speed;
   logic       error_flag;
   logic       new_output_flag;
   logic       frame_tick;
   logic       enable;
   logic       center;
   logic [9:0] paddle_y;
   logic       paddle_moving;
   logic       at_top;
   logic       at_bottom;
   logic       sample_dropped;

   int checks = 0;
   int failures = 0;
   int mtgt = 208;
   int mpy = 208;

   paddle_position_ctrl dut (
      .clk_25MHz       (clk_25MHz),
      .reset_n         (reset_n),
      .paddle_dir      (paddle_dir),
      .paddle_speed    (paddle_speed),
      .error_flag      (error_flag),
      .new_output_flag (new_output_flag),
      .frame_tick      (frame_tick),
      .enable          (enable),
      .center          (center),
      .paddle_y        (paddle_y),
      .paddle_moving   (paddle_moving),
      .at_top          (at_top),
      .at_bottom       (at_bottom),
      .sample_dropped  (sample_dropped)
   );

   always #20 clk_25MHz = ~clk_25MHz;

   initial begin
      #10ms;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   function automatic int clampi(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   task automatic m_sample(input bit d, input int sp);
      int dl;
      dl = sp / 2;
      if (dl < 2) dl = 0;
      mtgt = clampi(d ? mtgt + dl : mtgt - dl, 0, 416);
   endtask

   task automatic m_tick();
      mpy = mpy + clampi(mtgt - mpy, -8, 8);
   endtask

   task automatic cyc();
      @(posedge clk_25MHz);
      #1;
   endtask

   task automatic strobe(input bit d, input int sp, input bit err);
      paddle_dir      = d;
      paddle_speed    = 8'(sp);
      error_flag      = err;
      new_output_flag = 1'b1;
      cyc();
      new_output_flag = 1'b0;
      error_flag      = 1'b0;
      paddle_dir      = 1'($urandom);
      paddle_speed    = 8'($urandom);
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) cyc();
      @(negedge clk_25MHz);
      reset_n = 1'b1;
      cyc();
      mtgt = 208;
      mpy  = 208;
      checks++;
      if (paddle_y !== 10'd208) begin
         failures++;
         $display("FAIL reset_y got=%0d want=208", paddle_y);
      end
      checks++;
      if ({paddle_moving, at_top, at_bottom, sample_dropped} !== 4'b0) begin
         failures++;
         $display("FAIL reset_flags got=%b want=0000",
                  {paddle_moving, at_top, at_bottom, sample_dropped});
      end
   endtask

   task automatic test_basic();
      strobe(1'b1, 20, 1'b0);
      checks++;
      if (sample_dropped !== 1'b0) begin
         failures++;
         $display("FAIL basic_nodrop got=%b want=0", sample_dropped);
      end
      cyc();
      checks++;
      if (dut.target !== 10'd208) begin
         failures++;
         $display("FAIL basic_early got=%0d want=208", dut.target);
      end
      cyc();
      m_sample(1'b1, 20);
      checks++;
      if (dut.target !== 10'(mtgt) || mtgt != 218) begin
         failures++;
         $display("FAIL basic_target got=%0d want=218", dut.target);
      end
      tick();
      m_tick();
      checks++;
      if (paddle_y !== 10'(mpy) || paddle_moving !== 1'b1) begin
         failures++;
         $display("FAIL basic_tick1 got=%0d/%b want=%0d/1",
                  paddle_y, paddle_moving, mpy);
      end
      tick();
      m_tick();
      checks++;
      if (paddle_y !== 10'd218 || paddle_moving !== 1'b0) begin
         failures++;
         $display("FAIL basic_tick2 got=%0d/%b want=218/0",
                  paddle_y, paddle_moving);
      end
   endtask

   task automatic test_dead_zone();
      int old;
      old = mtgt;
      strobe(1'b1, 3, 1'b0);
      cyc();
      cyc();
      checks++;
      if (dut.target !== 10'(old)) begin
         failures++;
         $display("FAIL dz_speed3 got=%0d want=%0d", dut.target, old);
      end
      strobe(1'b0, 4, 1'b0);
      cyc();
      cyc();
      m_sample(1'b0, 4);
      checks++;
      if (dut.target !== 10'(old - 2)) begin
         failures++;
         $display("FAIL dz_speed4 got=%0d want=%0d", dut.target, old - 2);
      end
   endtask

   task automatic test_drop();
      int old;
      old = mtgt;
      strobe(1'b1, 100, 1'b1);
      checks++;
      if (sample_dropped !== 1'b1) begin
         failures++;
         $display("FAIL drop_err_pulse got=%b want=1", sample_dropped);
      end
      cyc();
      checks++;
      if (sample_dropped !== 1'b0) begin
         failures++;
         $display("FAIL drop_err_width got=%b want=0", sample_dropped);
      end
      cyc();
      checks++;
      if (dut.target !== 10'(old)) begin
         failures++;
         $display("FAIL drop_err_tgt got=%0d want=%0d", dut.target, old);
      end
      enable = 1'b0;
      strobe(1'b0, 100, 1'b0);
      enable = 1'b1;
      checks++;
      if (sample_dropped !== 1'b1) begin
         failures++;
         $display("FAIL drop_en_pulse got=%b want=1", sample_dropped);
      end
      cyc();
      cyc();
      checks++;
      if (dut.target !== 10'(old) || sample_dropped !== 1'b0) begin
         failures++;
         $display("FAIL drop_en_tgt got=%0d want=%0d", dut.target, old);
      end
      strobe(1'b1, 40, 1'b0);
      checks++;
      if (sample_dropped !== 1'b0) begin
         failures++;
         $display("FAIL b2b_first got=%b want=0", sample_dropped);
      end
      strobe(1'b0, 90, 1'b0);
      checks++;
      if (sample_dropped !== 1'b1) begin
         failures++;
         $display("FAIL b2b_second got=%b want=1", sample_dropped);
      end
      cyc();
      m_sample(1'b1, 40);
      checks++;
      if (dut.target !== 10'(mtgt) || sample_dropped !== 1'b0) begin
         failures++;
         $display("FAIL b2b_target got=%0d/%b want=%0d/0",
                  dut.target, sample_dropped, mtgt);
      end
   endtask

   task automatic test_saturate();
      for (int k = 0; k < 10; k++) begin
         strobe(1'b0, 255, 1'b0);
         cyc();
         cyc();
         m_sample(1'b0, 255);
         checks++;
         if (dut.target !== 10'(mtgt)) begin
            failures++;
            $display("FAIL sat_lo_tgt%0d got=%0d want=%0d", k, dut.target, mtgt);
         end
      end
      for (int k = 0; k < 60; k++) begin
         tick();
         m_tick();
         checks++;
         if (paddle_y !== 10'(mpy)) begin
            failures++;
            $display("FAIL sat_lo_y%0d got=%0d want=%0d", k, paddle_y, mpy);
         end
      end
      checks++;
      if (paddle_y !== 10'd0 || at_top !== 1'b1 || at_bottom !== 1'b0) begin
         failures++;
         $display("FAIL sat_top got=%0d/%b%b want=0/10", paddle_y, at_top, at_bottom);
      end
      for (int k = 0; k < 10; k++) begin
         strobe(1'b1, 255, 1'b0);
         cyc();
         cyc();
         m_sample(1'b1, 255);
         checks++;
         if (dut.target !== 10'(mtgt)) begin
            failures++;
            $display("FAIL sat_hi_tgt%0d got=%0d want=%0d", k, dut.target, mtgt);
         end
      end
      for (int k = 0; k < 60; k++) begin
         tick();
         m_tick();
         checks++;
         if (paddle_y !== 10'(mpy)) begin
            failures++;
            $display("FAIL sat_hi_y%0d got=%0d want=%0d", k, paddle_y, mpy);
         end
      end
      checks++;
      if (paddle_y !== 10'd416 || at_bottom !== 1'b1 || at_top !== 1'b0) begin
         failures++;
         $display("FAIL sat_bottom got=%0d/%b%b want=416/01", paddle_y, at_top, at_bottom);
      end
   endtask

   task automatic test_center();
      strobe(1'b0, 255, 1'b0);
      cyc();
      cyc();
      tick();
      strobe(1'b1, 100, 1'b0);
      center          = 1'b1;
      frame_tick      = 1'b1;
      new_output_flag = 1'b1;
      paddle_speed    = 8'd200;
      cyc();
      center          = 1'b0;
      frame_tick      = 1'b0;
      new_output_flag = 1'b0;
      mtgt = 208;
      mpy  = 208;
      checks++;
      if (dut.target !== 10'd208 || paddle_y !== 10'd208) begin
         failures++;
         $display("FAIL center_pos got=%0d/%0d want=208/208", dut.target, paddle_y);
      end
      checks++;
      if (paddle_moving !== 1'b0 || sample_dropped !== 1'b0 || dut.state !== IDLE) begin
         failures++;
         $display("FAIL center_flags got=%b%b st=%0d want=00 st=0",
                  paddle_moving, sample_dropped, dut.state);
      end
      repeat (3) cyc();
      checks++;
      if (dut.target !== 10'd208) begin
         failures++;
         $display("FAIL center_hold got=%0d want=208", dut.target);
      end
   endtask

   task automatic test_random();
      bit d, err, en;
      int sp;
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 2) != 0) begin
            d   = 1'($urandom);
            sp  = int'($urandom_range(0, 255));
            err = ($urandom_range(0, 7) == 0);
            en  = ($urandom_range(0, 7) != 0);
            enable = en;
            strobe(d, sp, err);
            enable = 1'b1;
            checks++;
            if (sample_dropped !== (err || !en)) begin
               failures++;
               $display("FAIL rnd_drop%0d got=%b want=%b", i, sample_dropped, err || !en);
            end
            cyc();
            cyc();
            if (!err && en) m_sample(d, sp);
            checks++;
            if (dut.target !== 10'(mtgt) || paddle_moving !== (mpy != mtgt)) begin
               failures++;
               $display("FAIL rnd_tgt%0d got=%0d/%b want=%0d/%b",
                        i, dut.target, paddle_moving, mtgt, mpy != mtgt);
            end
         end else begin
            en = ($urandom_range(0, 5) != 0);
            enable = en;
            tick();
            enable = 1'b1;
            if (en) m_tick();
            checks++;
            if (paddle_y !== 10'(mpy) || paddle_moving !== (mpy != mtgt) ||
                at_top !== (mpy == 0) || at_bottom !== (mpy == 416)) begin
               failures++;
               $display("FAIL rnd_y%0d got=%0d/%b%b%b want=%0d", i, paddle_y,
                        paddle_moving, at_top, at_bottom, mpy);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      strobe(1'b1, 255, 1'b0);
      cyc();
      cyc();
      m_sample(1'b1, 255);
      repeat (4) begin
         tick();
         m_tick();
      end
      checks++;
      if (paddle_y !== 10'(mpy) || mpy == 208) begin
         failures++;
         $display("FAIL ar_pre got=%0d want=%0d", paddle_y, mpy);
      end
      strobe(1'b0, 100, 1'b0);
      #5;
      reset_n = 1'b0;
      #1;
      checks++;
      if (paddle_y !== 10'd208 ||
          {paddle_moving, at_top, at_bottom, sample_dropped} !== 4'b0) begin
         failures++;
         $display("FAIL ar_immediate got=%0d/%b want=208/0000", paddle_y,
                  {paddle_moving, at_top, at_bottom, sample_dropped});
      end
      @(negedge clk_25MHz);
      reset_n = 1'b1;
      mtgt = 208;
      mpy  = 208;
      repeat (4) cyc();
      checks++;
      if (dut.target !== 10'd208 || paddle_y !== 10'd208 || paddle_moving !== 1'b0) begin
         failures++;
         $display("FAIL ar_after got=%0d/%0d/%b want=208/208/0",
                  dut.target, paddle_y, paddle_moving);
      end
   endtask

   initial begin
      reset_n         = 1'b0;
      paddle_dir      = 1'b0;
      paddle_speed    = '0;
      error_flag      = 1'b0;
      new_output_flag = 1'b0;
      frame_tick      = 1'b0;
      enable          = 1'b1;
      center          = 1'b0;
      test_reset();
      test_basic();
      test_dead_zone();
      test_drop();
      test_saturate();
      test_center();
      test_random();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
